// File: rtl/lottery_ticket_sender.sv
// lottery_ticket_sender
//   Transmit side of the lottery ticket scan protocol. A ticket (line count
//   plus up to MAX_LINES lines of 4 numbers) is latched on start. It is
//   checked once. It is then sent as a serial stream of items on N_out. Each
//   item is framed by a single scan strobe. The checker's SYSRDY gates the
//   start of transmission, and its RD_ERR aborts the transfer during the
//   post-strobe gap.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   send request, honoured only when idle
//   lines     in   [2:0] line count, legal 1..MAX_LINES
//   ticket    in   numbers; line L number k at [(L*4+k)*5 +: 5]
//   SYSRDY    in   checker ready, checked only while waiting to start
//   RD_ERR    in   checker read error, honoured only in the gap phase
//   N_out     out  [4:0] item value presented to the checker
//   scan      out  scan strobe
//   busy      out  high whenever not idle
//   done      out  one-cycle pulse, ticket fully sent
//   err       out  one-cycle pulse, ticket rejected or aborted
//   err_code  out  [1:0] 01 bad ticket, 10 read-error abort; held until next start

module lottery_ticket_sender #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 2,
  parameter int MAX_LINES = 4,
  parameter int MAX_NUM   = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               lines,
  input  logic [MAX_LINES*20-1:0]  ticket,
  input  logic                     SYSRDY,
  input  logic                     RD_ERR,
  output logic [4:0]               N_out,
  output logic                     scan,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code
);

  // state    | meaning
  // IDLE     | waiting for start; outputs quiet
  // CHECK    | one cycle validating the latched ticket
  // WAIT_RDY | valid ticket held until the checker raises SYSRDY
  // SETUP    | N_out driven with current item, scan low
  // PULSE    | scan high, N_out unchanged
  // GAP      | scan low, N_out unchanged, RD_ERR watched
  // DONE     | done pulse, back to IDLE
  // ERR      | err pulse, back to IDLE
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] WAIT_RDY = 3'd2;
  localparam logic [2:0] SETUP    = 3'd3;
  localparam logic [2:0] PULSE    = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  localparam logic [2:0] ERR      = 3'd7;

  localparam int SLOTS   = 4 * MAX_LINES;
  localparam int CYC_MAX = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                           : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  // The phase counter only ever holds (phase length - 1).
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  // The item index runs 0..4*MAX_LINES.
  localparam int ITEM_W  = $clog2(SLOTS + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  logic [2:0]               state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ITEM_W-1:0]        item_q;
  logic [2:0]               lines_q;
  logic [MAX_LINES*20-1:0]  ticket_q;
  logic [1:0]               err_code_q;

  logic                     ticket_ok;
  logic                     last_item;
  logic [4:0]               item_val;

  // Only the first 4*lines slots are validated. Later slots are never sent,
  // so their contents do not matter.
  always_comb begin
    ticket_ok = 1'b1;
    if (lines_q == 3'd0 || int'(lines_q) > MAX_LINES) begin
      ticket_ok = 1'b0;
    end
    for (int s = 0; s < SLOTS; s++) begin
      if ((s / 4) < int'(lines_q)) begin
        if (ticket_q[s*5 +: 5] == 5'd0 || int'(ticket_q[s*5 +: 5]) > MAX_NUM) begin
          ticket_ok = 1'b0;
        end
      end
    end
  end

  // Item 0 is the line count. Item i (i >= 1) is slot i-1. Slots are in
  // line-major order, matching the packing of the ticket bus.
  always_comb begin
    item_val = {2'b00, lines_q};
    for (int i = 0; i < SLOTS; i++) begin
      if (item_q == ITEM_W'(i + 1)) begin
        item_val = ticket_q[i*5 +: 5];
      end
    end
  end

  // The last item index is 4*lines, which is T-1.
  assign last_item = (item_q == ITEM_W'({lines_q, 2'b00}));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      item_q     <= '0;
      lines_q    <= '0;
      ticket_q   <= '0;
      err_code_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            lines_q    <= lines;
            ticket_q   <= ticket;
            err_code_q <= 2'b00;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (!ticket_ok) begin
            err_code_q <= 2'b01;
            state_q    <= ERR;
          end else begin
            state_q    <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (SYSRDY) begin
            item_q  <= '0;
            cnt_q   <= SETUP_LD;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            cnt_q   <= PULSE_LD;
            state_q <= PULSE;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            cnt_q   <= GAP_LD;
            state_q <= GAP;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          // A read error on any gap cycle wins over the phase timer.
          if (RD_ERR) begin
            err_code_q <= 2'b10;
            state_q    <= ERR;
          end else if (cnt_q == '0) begin
            if (last_item) begin
              state_q <= DONE;
            end else begin
              item_q  <= item_q + ITEM_W'(1);
              cnt_q   <= SETUP_LD;
              state_q <= SETUP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from state, so a reset quiets them one cycle later.
  always_comb begin
    N_out = 5'd0;
    if (state_q == SETUP || state_q == PULSE || state_q == GAP) begin
      N_out = item_val;
    end
  end

  assign scan     = (state_q == PULSE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign err_code = err_code_q;

endmodule

// File: tb/tb_lottery_ticket_sender.sv
module tb_lottery_ticket_sender;

  localparam int SETUP    = 2;
  localparam int PULSE    = 1;
  localparam int GAP      = 2;
  localparam int ITEM_CYC = SETUP + PULSE + GAP;

  logic        clk = 1'b0;
  logic        reset, start, SYSRDY, RD_ERR;
  logic [2:0]  lines;
  logic [79:0] ticket;
  logic [4:0]  N_out;
  logic        scan, busy, done, err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  lottery_ticket_sender dut (
    .clk(clk), .reset(reset), .start(start), .lines(lines), .ticket(ticket),
    .SYSRDY(SYSRDY), .RD_ERR(RD_ERR), .N_out(N_out), .scan(scan),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  lines;
    logic [79:0] ticket;
    int          rdy_delay;    // 0: SYSRDY high from start, else cycle it rises
    int          rderr_pulse;  // 0: none, else RD_ERR in gap after this pulse
    bit          mid_start;
    int          exp_pulses;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [19:0] mk4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [4:0] exp_items[17];
    logic [4:0] got[17];
    int         pcyc[17];
    int         pulses, cyc, r_eff, done_n, err_n, done_cyc, n_chk;
    logic       prev_scan;
    bit         b2b, idle_bad;

    exp_items[0] = {2'b00, v.lines};
    for (int i = 0; i < 16; i++) exp_items[i+1] = v.ticket[i*5 +: 5];
    r_eff    = (v.rdy_delay < 1) ? 1 : v.rdy_delay;
    pulses   = 0; done_n = 0; err_n = 0; done_cyc = -1;
    prev_scan = 1'b0; b2b = 1'b0; idle_bad = 1'b0;

    lines  = v.lines;
    ticket = v.ticket;
    SYSRDY = (v.rdy_delay == 0);
    RD_ERR = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lines  = ~v.lines;
    ticket = ~v.ticket;
    chk({v.name, " err_code_cleared"}, err_code, 0);

    cyc = 0;
    while (busy && cyc < 600) begin
      if (scan) begin
        if (prev_scan) b2b = 1'b1;
        if (pulses < 17) begin
          got[pulses]  = N_out;
          pcyc[pulses] = cyc;
        end
        pulses++;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err) err_n++;
      if (cyc >= 1 && cyc <= r_eff && (scan || N_out != 5'd0 || !busy)) idle_bad = 1'b1;
      RD_ERR = (cyc == 1);  // outside GAP, must be ignored
      if (v.rdy_delay > 0 && cyc == v.rdy_delay) SYSRDY = 1'b1;
      if (!scan && prev_scan && pulses == v.rderr_pulse) RD_ERR = 1'b1;
      if (v.mid_start) start = (cyc == 20);
      prev_scan = scan;
      tick();
      cyc++;
    end
    start  = 1'b0;
    RD_ERR = 1'b0;
    SYSRDY = 1'b0;

    chk({v.name, " finished_in_budget"}, busy, 0);
    chk({v.name, " pulse_count"}, pulses, v.exp_pulses);
    n_chk = (pulses < v.exp_pulses) ? pulses : v.exp_pulses;
    if (n_chk > 17) n_chk = 17;
    for (int i = 0; i < n_chk; i++) begin
      chk($sformatf("%s item%0d_value", v.name, i), got[i], exp_items[i]);
      chk($sformatf("%s item%0d_cycle", v.name, i), pcyc[i], r_eff + 1 + SETUP + i * ITEM_CYC);
    end
    chk({v.name, " done_count"}, done_n, (v.exp_code == 2'b00) ? 1 : 0);
    chk({v.name, " err_count"}, err_n, (v.exp_code == 2'b00) ? 0 : 1);
    if (v.exp_code == 2'b00)
      chk({v.name, " done_cycle"}, done_cyc, r_eff + 1 + ITEM_CYC * (1 + 4 * int'(v.lines)));
    chk({v.name, " back_to_back_scan"}, b2b, 0);
    chk({v.name, " quiet_before_ready"}, idle_bad, 0);
    chk({v.name, " err_code"}, err_code, v.exp_code);
    chk({v.name, " N_out_idle"}, N_out, 0);
    tick();
    tick();
    chk({v.name, " err_code_held"}, err_code, v.exp_code);
  endtask

  initial begin
    vecs[0]  = '{"t2_one_line", 3'd1, {60'd0, mk4(5, 20, 24, 28)}, 0, 0, 1'b0, 5, 2'b00};
    vecs[1]  = '{"t3_four_lines", 3'd4, {mk4(1, 3, 22, 26), mk4(1, 3, 22, 26), mk4(1, 3, 22, 26), mk4(1, 3, 22, 26)}, 0, 0, 1'b1, 17, 2'b00};
    vecs[2]  = '{"t4_lines0", 3'd0, {60'd0, mk4(5, 6, 7, 8)}, 0, 0, 1'b0, 0, 2'b01};
    vecs[3]  = '{"t4_num31", 3'd1, {60'd0, mk4(5, 31, 7, 9)}, 0, 0, 1'b0, 0, 2'b01};
    vecs[4]  = '{"t4_lines5", 3'd5, {mk4(1, 2, 3, 4), mk4(1, 2, 3, 4), mk4(1, 2, 3, 4), mk4(1, 2, 3, 4)}, 0, 0, 1'b0, 0, 2'b01};
    vecs[5]  = '{"t5_late_rdy", 3'd2, {40'd0, mk4(9, 8, 7, 6), mk4(2, 4, 6, 8)}, 10, 0, 1'b0, 9, 2'b00};
    vecs[6]  = '{"t6_rderr3", 3'd2, {40'd0, mk4(11, 12, 13, 14), mk4(15, 16, 17, 18)}, 0, 3, 1'b0, 3, 2'b10};
    vecs[7]  = '{"t6_resend", 3'd2, {40'd0, mk4(11, 12, 13, 14), mk4(15, 16, 17, 18)}, 0, 0, 1'b0, 9, 2'b00};
    vecs[8]  = '{"unused_slots_dc", 3'd3, {mk4(0, 31, 0, 31), mk4(27, 28, 29, 30), mk4(10, 11, 12, 13), mk4(1, 2, 3, 4)}, 0, 0, 1'b0, 13, 2'b00};
    vecs[9]  = '{"num_zero", 3'd1, {60'd0, mk4(0, 5, 6, 7)}, 0, 0, 1'b0, 0, 2'b01};
    vecs[10] = '{"max_num_30", 3'd4, {mk4(30, 1, 30, 1), mk4(1, 30, 1, 30), mk4(30, 30, 30, 30), mk4(1, 1, 1, 1)}, 0, 0, 1'b0, 17, 2'b00};
    vecs[11] = '{"rderr_last", 3'd1, {60'd0, mk4(3, 4, 5, 6)}, 3, 5, 1'b0, 5, 2'b10};

    reset = 1'b1; start = 1'b0; SYSRDY = 1'b0; RD_ERR = 1'b0;
    lines = 3'd0; ticket = 80'd0;
    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset scan", scan, 0);
    chk("reset N_out", N_out, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset err_code", err_code, 0);
    reset = 1'b0;
    tick();

    // Reset asserted while scan is high.
    begin
      int  w;
      bit  spurious;
      spurious = 1'b0;
      lines = 3'd1; ticket = {60'd0, mk4(5, 20, 24, 28)}; SYSRDY = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!scan && w < 50) begin
        tick();
        w++;
      end
      chk("t1 reached_pulse", scan, 1);
      reset = 1'b1;
      tick();
      chk("t1 scan_after_reset", scan, 0);
      chk("t1 busy_after_reset", busy, 0);
      chk("t1 N_out_after_reset", N_out, 0);
      if (done || err) spurious = 1'b1;
      tick();
      if (done || err) spurious = 1'b1;
      reset = 1'b0;
      SYSRDY = 1'b0;
      tick();
      if (done || err) spurious = 1'b1;
      chk("t1 no_done_err_pulse", spurious, 0);
      chk("t1 stays_idle", busy, 0);
    end

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
